hyperpacket_tx: RTL and testbench

Host-side initiator for the 2x2 matrix-multiply hyperpacket protocol. It serialises one job (job ID, matrix A, matrix B) into two 8-byte hyperpackets over the uart byte-transmit interface. It then collects the responder's job-ID echo and the 5-byte result (job ID, c11, c12, c21, c22) from the uart receive interface. It sits beside the uart block and lets on-chip logic, or a loopback test, act as the far end of the matrix engine.

---
 rtl/hyperpacket_tx.sv | 180 ++++++++++++++++++
 tb/tb_hyperpacket_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hyperpacket_tx.sv
// Host-side initiator: serialises one 2x2 matrix job into two 8-byte hyperpackets, then collects echo and 5-byte result.
// Latency: first send_request one clk after accept (busy low); res_valid one clk after the 5th result strobe or on timeout.
// Backpressure: waits on uart busy between bytes; job_ready is high only while idle.
module hyperpacket_tx #(
    parameter int unsigned RESP_TIMEOUT = 12000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_id,
    input  logic [31:0] a_mat,
    input  logic [31:0] b_mat,
    output logic [7:0]  tx_byte,
    output logic        send_request,
    input  logic        busy,
    input  logic [7:0]  rx_byte,
    input  logic        byte_available,
    output logic        res_valid,
    output logic [7:0]  res_job_id,
    output logic [31:0] c_mat,
    output logic [1:0]  res_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAITTX,
        S_RESP
    } state_t;

    localparam logic [23:0] TIMEOUT_LAST = 24'(RESP_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  job_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  idx;
    logic        echo_seen;
    logic [1:0]  err;
    logic [2:0]  rcnt;
    logic [23:0] tcnt;
    logic [7:0]  cap_id;
    logic [31:0] cap_c;

    logic accept, last_tx, rx_echo, rx_result, result_done, timed_out;

    assign accept      = job_valid && job_ready;
    assign last_tx     = (state == S_WAITTX) && !busy && (idx == 4'd15);
    assign rx_echo     = byte_available && !echo_seen && (state != S_IDLE);
    assign rx_result   = byte_available && echo_seen && (state == S_RESP);
    assign result_done = rx_result && (rcnt == 3'd4);
    assign timed_out   = (state == S_RESP) && (tcnt == TIMEOUT_LAST) && !result_done;

    // Byte i of the 16-byte stream; the 0xFF opcode is not part of the checksum.
    function automatic logic [7:0] byte_at(input logic [3:0] i);
        logic [31:0] m;
        logic [7:0]  chk;
        m   = i[3] ? b_q : a_q;
        chk = {7'd0, i[3]} + job_q + m[31:24] + m[23:16] + m[15:8] + m[7:0];
        case (i[2:0])
            3'd0:    byte_at = 8'hFF;
            3'd1:    byte_at = {7'd0, i[3]};
            3'd2:    byte_at = job_q;
            3'd3:    byte_at = m[31:24];
            3'd4:    byte_at = m[23:16];
            3'd5:    byte_at = m[15:8];
            3'd6:    byte_at = m[7:0];
            default: byte_at = chk;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        job_ready    = 1'b0;
        send_request = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = !rst;
                if (job_valid && !rst) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!busy) begin
                    send_request = !rst;
                    state_nxt    = S_HOLD;
                end
            end
            S_HOLD: state_nxt = S_WAITTX;
            S_WAITTX: begin
                if (!busy) state_nxt = (idx == 4'd15) ? S_RESP : S_SEND;
            end
            S_RESP: begin
                if (result_done || timed_out) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            echo_seen  <= 1'b0;
            err        <= '0;
            rcnt       <= '0;
            tcnt       <= '0;
            cap_id     <= '0;
            cap_c      <= '0;
            tx_byte    <= '0;
            res_valid  <= 1'b0;
            res_job_id <= '0;
            c_mat      <= '0;
            res_err    <= '0;
        end else begin
            res_valid <= 1'b0;

            if (accept) begin
                job_q     <= job_id;
                a_q       <= a_mat;
                b_q       <= b_mat;
                idx       <= '0;
                echo_seen <= 1'b0;
                err       <= '0;
                rcnt      <= '0;
                cap_id    <= '0;
                cap_c     <= '0;
                tx_byte   <= 8'hFF;
            end

            // tx_byte only moves once the previous byte has left the uart.
            if ((state == S_WAITTX) && !busy && (idx != 4'd15)) begin
                idx     <= idx + 4'd1;
                tx_byte <= byte_at(idx + 4'd1);
            end

            if (last_tx)               tcnt <= '0;
            else if (state == S_RESP)  tcnt <= tcnt + 24'd1;

            if (rx_echo) begin
                echo_seen <= 1'b1;
                if (rx_byte != job_q) err <= 2'd1;
            end

            if (rx_result) begin
                rcnt <= rcnt + 3'd1;
                case (rcnt)
                    3'd0: begin
                        cap_id <= rx_byte;
                        if ((rx_byte != job_q) && (err == 2'd0)) err <= 2'd2;
                    end
                    3'd1:    cap_c[31:24] <= rx_byte;
                    3'd2:    cap_c[23:16] <= rx_byte;
                    3'd3:    cap_c[15:8]  <= rx_byte;
                    default: ;
                endcase
            end

            // Missing result bytes on timeout stay at the zeros loaded on accept.
            if (result_done) begin
                res_valid  <= 1'b1;
                res_job_id <= cap_id;
                c_mat      <= {cap_c[31:8], rx_byte};
                res_err    <= err;
            end else if (timed_out) begin
                res_valid  <= 1'b1;
                res_job_id <= cap_id;
                c_mat      <= cap_c;
                res_err    <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_hyperpacket_tx.sv
// Self-checking bench for hyperpacket_tx: uart busy model, scripted responder, tx and result scoreboards.
module tb_hyperpacket_tx;

    localparam int TO       = 1000;
    localparam int BUSY_LEN = 10;
    localparam int LIMIT    = 3000;

    logic        clk, rst;
    logic        job_valid, job_ready;
    logic [7:0]  job_id;
    logic [31:0] a_mat, b_mat;
    logic [7:0]  tx_byte;
    logic        send_request, busy;
    logic [7:0]  rx_byte;
    logic        byte_available;
    logic        res_valid;
    logic [7:0]  res_job_id;
    logic [31:0] c_mat;
    logic [1:0]  res_err;

    hyperpacket_tx #(.RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .a_mat(a_mat), .b_mat(b_mat),
        .tx_byte(tx_byte), .send_request(send_request), .busy(busy),
        .rx_byte(rx_byte), .byte_available(byte_available),
        .res_valid(res_valid), .res_job_id(res_job_id), .c_mat(c_mat), .res_err(res_err)
    );

    typedef struct {
        logic [7:0]  rid;
        logic [31:0] c;
        logic [1:0]  err;
        bit          timed;
    } res_t;

    logic [7:0] tx_exp[$];
    res_t       res_exp[$];
    int total = 0, bad = 0;
    int cyc = 0, n_send = 0, res_seen = 0, last_req = 0;
    int busy_cnt = 0;
    logic [7:0] mon_b;
    res_t       mon_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // uart transmitter: busy from the cycle after send_request for BUSY_LEN cycles
    always @(posedge clk) begin
        if (send_request)      busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] id, input logic [31:0] a,
                                              input logic [31:0] b, input int i);
        logic [31:0] m;
        int sum;
        m   = (i >= 8) ? b : a;
        sum = (i >= 8 ? 1 : 0) + int'(id) + int'(m[31:24]) + int'(m[23:16]) + int'(m[15:8]) + int'(m[7:0]);
        case (i % 8)
            0: return 8'hFF;
            1: return (i >= 8) ? 8'h01 : 8'h00;
            2: return id;
            3: return m[31:24];
            4: return m[23:16];
            5: return m[15:8];
            6: return m[7:0];
            default: return 8'(sum % 256);
        endcase
    endfunction

    always @(negedge clk) begin
        if (send_request) begin
            n_send++;
            last_req = cyc;
            check("req_while_busy", busy, 0);
            if (tx_exp.size() == 0) check("tx_extra", 64'(tx_exp.size()), 1);
            else begin
                mon_b = tx_exp.pop_front();
                check("tx_byte", tx_byte, mon_b);
            end
        end
        if (res_valid) begin
            res_seen++;
            if (res_exp.size() == 0) check("res_extra", 64'(res_exp.size()), 1);
            else begin
                mon_r = res_exp.pop_front();
                check("res_job_id", res_job_id, mon_r.rid);
                check("c_mat", c_mat, mon_r.c);
                check("res_err", res_err, mon_r.err);
                if (mon_r.timed) check("timeout_cycle", cyc, last_req + BUSY_LEN + 2 + TO);
            end
        end
    end

    task automatic rx_send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; byte_available = 1'b1;
        @(posedge clk); #1;
        byte_available = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic wait_sends(input int target, input string tag);
        int t = 0;
        while (n_send < target && t < LIMIT) begin @(negedge clk); t++; end
        if (t >= LIMIT) check(tag, n_send, target);
    endtask

    task automatic start_job(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        for (int i = 0; i < 16; i++) tx_exp.push_back(model_byte(id, a, b, i));
        @(posedge clk); #1;
        job_valid = 1'b1; job_id = id; a_mat = a; b_mat = b;
        @(negedge clk);
        while (!job_ready && t < LIMIT) begin @(negedge clk); t++; end
        check("job_ready_idle", job_ready, 1);
        // hold job_valid with different data after accept; it must be ignored
        @(posedge clk); #1;
        job_id = ~id; a_mat = ~a; b_mat = ~b;
        @(negedge clk);
        check("first_req_latency", send_request, 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] echo, input bit early_echo,
                           input logic [39:0] rb, input int nrb,
                           input logic [7:0] erid, input logic [31:0] ec, input logic [1:0] eerr);
        res_t r;
        int base, rs0, t;
        base = n_send;
        rs0  = res_seen;
        r.rid = erid; r.c = ec; r.err = eerr; r.timed = (eerr == 2'd3);
        res_exp.push_back(r);
        start_job(id, a, b);
        if (early_echo) begin
            wait_sends(base + 3, "wait_echo_point");
            rx_send(echo);
        end
        wait_sends(base + 16, "wait_all_tx");
        // first responder strobe lands in the RESP entry cycle
        repeat (11) @(posedge clk);
        if (!early_echo) rx_send(echo);
        for (int i = 0; i < nrb; i++) rx_send(rb[39 - 8*i -: 8]);
        if (nrb == 5) begin
            @(negedge clk);
            check("res_latency", res_valid, 1);
        end
        t = 0;
        while (res_seen == rs0 && t < TO + 300) begin @(negedge clk); t++; end
        check("res_count", res_seen - rs0, 1);
        check("tx_count", n_send - base, 16);
        @(negedge clk);
        check("job_ready_back", job_ready, 1);
        repeat (5) @(negedge clk);
        check("single_res", res_seen - rs0, 1);
    endtask

    initial begin
        int s;
        rst = 1'b1; job_valid = 1'b0; job_id = '0; a_mat = '0; b_mat = '0;
        rx_byte = '0; byte_available = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_ready", job_ready, 0);
        check("rst_send_request", send_request, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_job_ready", job_ready, 1);
        check("post_rst_tx_byte", tx_byte, 0);
        check("post_rst_c_mat", c_mat, 0);
        check("post_rst_res_err", res_err, 0);

        // stray rx in IDLE must not count as an echo
        rx_send(8'h55);
        run_job(8'h2A, 32'h01020304, 32'h05060708, 8'h2A, 1'b1, 40'h2A13162B32, 5, 8'h2A, 32'h13162B32, 2'd0);
        run_job(8'hFF, 32'hFFFFFFFF, 32'h00000000, 8'hFF, 1'b1, 40'hFF00000001, 5, 8'hFF, 32'h00000001, 2'd0);
        run_job(8'h2A, 32'h01020304, 32'h05060708, 8'h2B, 1'b1, 40'h2B13162B32, 5, 8'h2B, 32'h13162B32, 2'd1);
        run_job(8'h2A, 32'h01020304, 32'h05060708, 8'h2A, 1'b0, 40'h2C13162B32, 5, 8'h2C, 32'h13162B32, 2'd2);
        run_job(8'h2A, 32'h01020304, 32'h05060708, 8'h2A, 1'b1, 40'h2A13000000, 2, 8'h2A, 32'h13000000, 2'd3);

        // reset while byte index 9 is in flight
        s = n_send;
        start_job(8'h2A, 32'h01020304, 32'h05060708);
        wait_sends(s + 10, "wait_idx9");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_job_ready", job_ready, 0);
        check("midrst_send_request", send_request, 0);
        @(posedge clk); #1;
        tx_exp.delete();
        res_exp.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_job_ready_after", job_ready, 1);
        check("midrst_tx_byte", tx_byte, 0);
        check("midrst_res_job_id", res_job_id, 0);
        check("midrst_c_mat", c_mat, 0);
        check("midrst_res_err", res_err, 0);
        check("midrst_res_valid", res_valid, 0);
        s = n_send;
        repeat (50) @(negedge clk);
        check("no_req_after_rst", n_send, s);

        run_job(8'h11, 32'h10203040, 32'h0A0B0C0D, 8'h11, 1'b1, 40'h11AABBCCDD, 5, 8'h11, 32'hAABBCCDD, 2'd0);
        check("tx_queue_drained", 64'(tx_exp.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
